// File: rtl/graydecoder.sv
// graydecoder: captures a Gray-coded bus word and decodes it to binary through a
// two-stage register pipeline. Define GRAYDEC_STATS_EN to build the toggle/step counters.
module graydecoder #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          vin,
  input  logic [N-1:0]  C,
  output logic [N-1:0]  A,
  output logic          vout,
  output logic [CW-1:0] TRANS,
  output logic [CW-1:0] SEQ
);

  function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [N-1:0] greg_q, greg_d;
  logic         v1_q, v1_d;
  logic [N-1:0] a_q, a_d;
  logic         vout_q, vout_d;
  logic [N-1:0] dec_s;

  assign dec_s = gray_to_bin(greg_q);

  // Pipeline next-state: capture on vin, decode on the stage-1 valid bit.
  always_comb begin
    greg_d = greg_q;
    v1_d   = vin;
    a_d    = a_q;
    vout_d = 1'b0;
    if (vin) begin
      greg_d = C;
    end else begin
      greg_d = greg_q;
    end
    if (v1_q) begin
      a_d    = dec_s;
      vout_d = 1'b1;
    end else begin
      a_d    = a_q;
      vout_d = 1'b0;
    end
  end

  // Pipeline registers.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      greg_q <= {N{1'b0}};
      v1_q   <= 1'b0;
      a_q    <= {N{1'b0}};
      vout_q <= 1'b0;
    end else begin
      greg_q <= greg_d;
      v1_q   <= v1_d;
      a_q    <= a_d;
      vout_q <= vout_d;
    end
  end

  assign A    = a_q;
  assign vout = vout_q;

`ifdef GRAYDEC_STATS_EN
  localparam int PW = $clog2(N + 1);
  // Sum width wide enough for either operand plus one carry bit.
  localparam int SW = ((CW > PW) ? CW : PW) + 1;
  localparam logic [SW-1:0] CNT_MAX = {{(SW-CW){1'b0}}, {CW{1'b1}}};
  localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};

  function automatic logic [SW-1:0] popcount(input logic [N-1:0] v);
    logic [SW-1:0] n;
    n = {SW{1'b0}};
    for (int i = 0; i < N; i++) begin
      n = n + {{(SW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cnt, input logic [SW-1:0] inc);
    logic [SW-1:0] sum;
    logic [CW-1:0] r;
    sum = {{(SW-CW){1'b0}}, cnt} + inc;
    if (sum > CNT_MAX) begin
      r = CNT_MAX[CW-1:0];
    end else begin
      r = sum[CW-1:0];
    end
    return r;
  endfunction

  logic [N-1:0]  gprev_q, gprev_d;
  logic          first_q, first_d;
  logic [CW-1:0] trans_q, trans_d;
  logic [CW-1:0] seq_q, seq_d;
  logic [N-1:0]  a_inc_s;
  logic          step_s;

  // a_q still holds the previous decoded word while the new one is in stage 2.
  assign a_inc_s = a_q + {{(N-1){1'b0}}, 1'b1};
  assign step_s  = (dec_s == a_inc_s) && !first_q;

  // Statistics next-state, advanced together with the stage-2 output.
  always_comb begin
    gprev_d = gprev_q;
    first_d = first_q;
    trans_d = trans_q;
    seq_d   = seq_q;
    if (v1_q) begin
      gprev_d = greg_q;
      first_d = 1'b0;
      trans_d = sat_add(trans_q, popcount(greg_q ^ gprev_q));
      if (step_s) begin
        seq_d = sat_add(seq_q, CNT_ONE);
      end else begin
        seq_d = seq_q;
      end
    end else begin
      gprev_d = gprev_q;
      first_d = first_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      gprev_q <= {N{1'b0}};
      first_q <= 1'b1;
      trans_q <= {CW{1'b0}};
      seq_q   <= {CW{1'b0}};
    end else begin
      gprev_q <= gprev_d;
      first_q <= first_d;
      trans_q <= trans_d;
      seq_q   <= seq_d;
    end
  end

  assign TRANS = trans_q;
  assign SEQ   = seq_q;
`else
  assign TRANS = {CW{1'b0}};
  assign SEQ   = {CW{1'b0}};
`endif

endmodule

// File: doc/graydecoder.md
# graydecoder

Receive-side counterpart of the Gray bus encoder in the low-power bus-encoding suite. The block captures a Gray-coded bus word, converts it back to binary through a two-stage register pipeline, and flags when the output is valid. A compile-time option adds on-chip activity statistics: the bus toggle count and the count of sequential-address steps. These feed the switching-activity and power analysis of address-like and data-like traffic.

## Interface
- N, 8, bus width in bits (N ≥ 2)
- CW, 16, width of each statistics counter

- ck  input  1  clock, rising-edge active
- rst  input  1  asynchronous reset, active-low: rst = 0 resets all state immediately
- vin  input  1  input word valid; C is sampled only when vin = 1
- C  input  N  Gray-coded bus word
- A  output  N  decoded binary word, registered
- vout  output  1  A holds a newly decoded word this cycle
- TRANS  output  CW  saturating count of bit toggles on accepted Gray words
- SEQ  output  CW  saturating count of accepted words equal to the previous word + 1

## Operation
- Decode rule: A[N-1] = G[N-1], and A[i] = A[i+1] XOR G[i] for i = N-2 down to 0. The decode is combinational between stage 1 and stage 2.
- Stage 1, on each rising ck edge:
  - greg ← C when vin = 1; greg holds otherwise.
  - v1 ← vin.
- Stage 2, on each rising ck edge:
  - If v1 = 1: A ← decode(greg) and vout ← 1.
  - If v1 = 0: A holds and vout ← 0.
- Toggle tracking (stats build only):
  - gprev holds the last accepted Gray word; its reset value is 0.
  - When v1 = 1: TRANS ← sat(TRANS + popcount(greg XOR gprev)), then gprev ← greg.
  - The first word after reset is therefore compared against 0.
- Sequential tracking (stats build only):
  - A one-bit flag `first` is set by reset.
  - When v1 = 1 and first = 0: if decode(greg) == (A + 1) mod 2^N, then SEQ ← sat(SEQ + 1). The increment wraps, so 2^N-1 followed by 0 counts as a step.
  - When v1 = 1: first ← 0.
- Saturation: TRANS and SEQ stop at 2^CW - 1 and never wrap.
- No state machine beyond the pipeline valid bits and `first`. There is no backpressure; every valid input word produces exactly one output word.

## Timing
- Reset values, all asynchronous on rst = 0: A = 0, vout = 0, TRANS = 0, SEQ = 0, greg = 0, gprev = 0, v1 = 0, first = 1.
- Latency is 2 cycles. If vin = 1 is sampled at edge k, then A and vout = 1 appear after edge k+1 and are stable through edge k+2.
- Throughput is one word per cycle. Back-to-back vin = 1 gives back-to-back vout = 1.
- vout is a one-cycle pulse per word. With vin = 0, A holds its last decoded value.
- TRANS and SEQ update on the same edge as A, so counts for a word are visible together with that word.
- Reset mid-stream:
  - Words still in flight are discarded and vout = 0 immediately.
  - The first valid word after release is never counted in SEQ.
  - That word's toggle count is taken against 0.
- Reset release is assumed synchronous to ck at the integration level; the block does not synchronize rst.

## Configuration
- GRAYDEC_STATS_EN defined: gprev, `first`, popcount, incrementer, comparator and both counters are built as described above.
- GRAYDEC_STATS_EN undefined: none of that logic is built. TRANS and SEQ are tied to 0. A and vout behave identically to the stats build.

## Test plan
- Reset check: hold rst = 0, drive C = 8'hFF with vin = 1. A stays 0, vout stays 0, TRANS = 0, SEQ = 0.
- Decode and latency:
  - C = 8'b1100_0101 with vin = 1 for one cycle. After 2 edges: A = 8'b1000_0110, vout = 1 for exactly one cycle.
  - Then vin = 0: A holds 8'h86.
- Sequential stream (stats build): drive Gray codes of 0..255 then 0, with vin = 1 every cycle.
  - A walks 0..255, 0.
  - SEQ = 256: the first word is not counted and the 255→0 wrap is counted.
  - TRANS = 256: one toggle per step after the first, plus the 255→0 step. The first word, 0, costs 0 toggles.
- Data stream (stats build): random 8-bit words from rndin.txt.
  - A matches a reference binary-to-Gray-to-binary round trip.
  - TRANS equals the bench-computed Hamming-distance sum.
  - vout count equals the vin count.
- Saturation: build with CW = 4 and alternate C = 8'h00 / 8'hFF. TRANS saturates at 15 and stays there.
- Reset mid-operation and macro-off build:
  - Assert rst = 0 while one word is in stage 1. That word never appears and TRANS/SEQ clear.
  - With GRAYDEC_STATS_EN undefined, rerun the sequential stream. A and vout are identical to the stats build; TRANS = SEQ = 0.
